// File: rtl/gate_bist_checker.sv
// gate_bist_checker: sweeps a 2-input gate through all four {a,b} vectors and checks y against a truth table
module gate_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECT_TT     = 4'b1000,
  parameter bit          STOP_ON_FAIL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx,
  output logic       fail_y,
  output logic [2:0] pass_count
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0] SC     = 4'(SETTLE_CYCLES);
  logic [1:0] state, idx;
  logic [3:0] cnt;
  logic       first_fail, match, last;
  // a/b come straight from the vector index register, so they hold the last vector in DONE
  assign a     = idx[1];
  assign b     = idx[0];
  assign busy  = (state == SETTLE) || (state == CHECK);
  assign done  = state == DONE;
  assign match = y == EXPECT_TT[idx];
  assign last  = (!match && STOP_ON_FAIL) || idx == 2'd3;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      first_fail <= 1'b0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      fail_y     <= 1'b0;
      pass_count <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      state      <= SETTLE;
      idx        <= '0;
      cnt        <= SC;
      first_fail <= 1'b0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      fail_y     <= 1'b0;
      pass_count <= '0;
    end else if (state == SETTLE) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) state <= CHECK;
    end else if (state == CHECK) begin
      if (match) pass_count <= pass_count + 3'd1;
      else if (!first_fail) begin
        fail_idx   <= idx;
        fail_y     <= y;
        first_fail <= 1'b1;
      end
      if (last) begin
        state <= DONE;
        pass  <= match && !first_fail && idx == 2'd3;
      end else begin
        idx   <= idx + 2'd1;
        cnt   <= SC;
        state <= SETTLE;
      end
    end
  end
endmodule
